// File: rtl/fpu_add_result_fifo_if.sv
// Handshake bundle between the FP adder, the result FIFO and its consumer.
// The FIFO takes the slave view; the upstream/downstream driver takes the master view.
interface fpu_add_result_fifo_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_result, in_nan, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_result, in_nan, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fpu_add_result_fifo.sv
// Result FIFO behind the single-precision FP adder: classifies each accepted word,
// buffers it with its flags, and keeps sticky exception flags plus a saturating count.
module fpu_add_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  fpu_add_result_fifo_if.slave     bus,
  input  logic                     clr_sticky,
  output logic [3:0]               sticky_flags,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         result_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [3:0]       flg_q [DEPTH];
  logic [3:0]       flg_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0]  exp_f;
  logic [22:0] frac_f;
  logic        is_nan, is_inf, is_zero, is_neg;
  logic [3:0]  in_flags;
  logic        accept, take;

  always_comb begin
    exp_f    = bus.in_result[30:23];
    frac_f   = bus.in_result[22:0];
    is_nan   = bus.in_nan | ((exp_f == 8'hFF) & (frac_f != 23'd0));
    is_inf   = (exp_f == 8'hFF) & (frac_f == 23'd0) & ~is_nan;
    is_zero  = (exp_f == 8'h00);
    is_neg   = bus.in_result[31];
    in_flags = {is_nan, is_inf, is_zero, is_neg};

    // Handshakes only look at registered ready/valid, so no comb path crosses the FIFO.
    accept = bus.in_valid & in_ready_q;
    take   = out_valid_q & bus.out_ready;

    mem_d    = mem_q;
    flg_d    = flg_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (accept) begin
      mem_d[wr_ptr_q] = bus.in_result;
      flg_d[wr_ptr_q] = in_flags;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (take) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (accept && !take) begin
      level_d = level_q + LVL_W'(1);
    end else if (take && !accept) begin
      level_d = level_q - LVL_W'(1);
    end

    in_ready_d  = (level_d != LVL_W'(DEPTH));
    out_valid_d = (level_d != LVL_W'(0));

    if (clr_sticky) begin
      sticky_d = accept ? in_flags : 4'b0000;
    end else begin
      sticky_d = sticky_q | (accept ? in_flags : 4'b0000);
    end

    cnt_d = cnt_q;
    if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Storage is cleared on reset too, so nothing from before reset reaches the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
        flg_q[i] <= 4'd0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sticky_q    <= 4'd0;
      cnt_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      flg_q       <= flg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = mem_q[rd_ptr_q];
  assign bus.out_flags  = flg_q[rd_ptr_q];
  assign sticky_flags   = sticky_q;
  assign level          = level_q;
  assign result_cnt     = cnt_q;

endmodule

// File: tb/tb_fpu_add_result_fifo.sv
// Directed bench for fpu_add_result_fifo: main instance (DEPTH 4, CNT_W 16)
// plus a CNT_W 2 instance for counter saturation.
module tb_fpu_add_result_fifo;

  logic        clk;
  logic        rst;
  logic        clr_sticky;
  logic        clr_sticky_c;
  logic [3:0]  sticky;
  logic [3:0]  sticky_c;
  logic [2:0]  level;
  logic [2:0]  level_c;
  logic [15:0] cnt;
  logic [1:0]  cnt_c;

  int n_checks;
  int n_fail;

  fpu_add_result_fifo_if bus ();
  fpu_add_result_fifo_if bus_c ();

  fpu_add_result_fifo #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_sticky(clr_sticky),
    .sticky_flags(sticky), .level(level), .result_cnt(cnt)
  );

  fpu_add_result_fifo #(.DEPTH(4), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c), .clr_sticky(clr_sticky_c),
    .sticky_flags(sticky_c), .level(level_c), .result_cnt(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("[TB] FAIL rst_level: got %0d want 0", level); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.out_result !== 32'h0 || bus.out_flags !== 4'h0) begin n_fail++; $display("[TB] FAIL rst_head: got %h/%b want 0/0000", bus.out_result, bus.out_flags); end
    n_checks++; if (sticky !== 4'h0 || cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_status: got sticky %b cnt %0d want 0000/0", sticky, cnt); end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single_push();
    bus.in_valid  = 1'b1;
    bus.in_result = 32'h40400000;
    bus.in_nan    = 1'b0;
    tick();
    bus.in_valid  = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL single_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_result !== 32'h40400000) begin n_fail++; $display("[TB] FAIL single_result: got %h want 40400000", bus.out_result); end
    n_checks++; if (bus.out_flags !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_flags: got %b want 0000", bus.out_flags); end
    n_checks++; if (cnt !== 16'd1 || level !== 3'd1) begin n_fail++; $display("[TB] FAIL single_cnt_level: got %0d/%0d want 1/1", cnt, level); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("[TB] FAIL single_pop: got valid %b level %0d want 0/0", bus.out_valid, level); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] vals [4];
    logic [3:0]  flgs [4];
    vals[0] = 32'h3F800000; flgs[0] = 4'b0000;
    vals[1] = 32'hC0000000; flgs[1] = 4'b0001;
    vals[2] = 32'h00000000; flgs[2] = 4'b0010;
    vals[3] = 32'h7F800000; flgs[3] = 4'b0100;
    bus.in_nan = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_result = vals[i];
      tick();
    end
    n_checks++; if (level !== 3'd4) begin n_fail++; $display("[TB] FAIL fill_level: got %0d want 4", level); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_in_ready: got %b want 0", bus.in_ready); end
    bus.in_result = 32'h12345678;
    tick();
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (level !== 3'd4 || cnt !== 16'd5) begin n_fail++; $display("[TB] FAIL fill_overflow: got level %0d cnt %0d want 4/5", level, cnt); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== vals[i] || bus.out_flags !== flgs[i]) begin
        n_fail++; $display("[TB] FAIL drain_%0d: got %b %h %b want 1 %h %b", i, bus.out_valid, bus.out_result, bus.out_flags, vals[i], flgs[i]);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    n_checks++; if (level !== 3'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL drain_empty: got level %0d valid %b want 0/0", level, bus.out_valid); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("[TB] FAIL pop_empty: got level %0d want 0", level); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_result = 32'h41000000 + i;
      tick();
    end
    bus.in_result = 32'h41000004;
    bus.out_ready = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b0 || level !== 3'd4) begin n_fail++; $display("[TB] FAIL full_simul_ready: got ready %b level %0d want 0/4", bus.in_ready, level); end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++; if (level !== 3'd3 || bus.out_result !== 32'h41000001 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL full_simul_after: got level %0d head %h ready %b want 3 41000001 1", level, bus.out_result, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (level !== 3'd2 || bus.out_result !== 32'h41000002) begin n_fail++; $display("[TB] FAIL half_level: got %0d head %h want 2 41000002", level, bus.out_result); end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_result = 32'h41000004;
    tick();
    n_checks++; if (level !== 3'd2 || bus.out_result !== 32'h41000003) begin n_fail++; $display("[TB] FAIL pushpop_1: got %0d head %h want 2 41000003", level, bus.out_result); end
    bus.in_result = 32'h41000005;
    tick();
    n_checks++; if (level !== 3'd2 || bus.out_result !== 32'h41000004) begin n_fail++; $display("[TB] FAIL pushpop_2: got %0d head %h want 2 41000004", level, bus.out_result); end
    bus.in_valid  = 1'b0;
    tick();
    n_checks++; if (level !== 3'd1 || bus.out_result !== 32'h41000005) begin n_fail++; $display("[TB] FAIL pushpop_tail: got %0d head %h want 1 41000005", level, bus.out_result); end
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (level !== 3'd0 || cnt !== 16'd11) begin n_fail++; $display("[TB] FAIL pushpop_end: got level %0d cnt %0d want 0/11", level, cnt); end
  endtask

  task automatic test_flags();
    logic [31:0] vals [3];
    logic        nans [3];
    logic [3:0]  flgs [3];
    vals[0] = 32'h7FC00000; nans[0] = 1'b1; flgs[0] = 4'b1000;
    vals[1] = 32'hFF800000; nans[1] = 1'b0; flgs[1] = 4'b0101;
    vals[2] = 32'h80000000; nans[2] = 1'b0; flgs[2] = 4'b0011;
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_result = vals[i];
      bus.in_nan    = nans[i];
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_nan   = 1'b0;
    n_checks++; if (sticky !== 4'b1111) begin n_fail++; $display("[TB] FAIL flags_sticky: got %b want 1111", sticky); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.out_result !== vals[i] || bus.out_flags !== flgs[i]) begin
        n_fail++; $display("[TB] FAIL flags_%0d: got %h %b want %h %b", i, bus.out_result, bus.out_flags, vals[i], flgs[i]);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_sticky_clear();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    n_checks++; if (sticky !== 4'b0000 || cnt !== 16'd14) begin n_fail++; $display("[TB] FAIL clr_alone: got sticky %b cnt %0d want 0000/14", sticky, cnt); end
    clr_sticky    = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_result = 32'h7F800000;
    bus.in_nan    = 1'b0;
    tick();
    clr_sticky   = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++; if (sticky !== 4'b0100 || cnt !== 16'd15) begin n_fail++; $display("[TB] FAIL clr_with_push: got sticky %b cnt %0d want 0100/15", sticky, cnt); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_result = 32'hC1200000 + i;
      tick();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (level !== 3'd3) begin n_fail++; $display("[TB] FAIL mid_pre_level: got %0d want 3", level); end
    rst = 1'b1;
    tick();
    n_checks++; if (level !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_result !== 32'h0) begin
      n_fail++; $display("[TB] FAIL mid_rst_fifo: got level %0d valid %b head %h want 0 0 0", level, bus.out_valid, bus.out_result);
    end
    n_checks++; if (sticky !== 4'h0 || cnt !== 16'd0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mid_rst_status: got sticky %b cnt %0d ready %b want 0000 0 0", sticky, cnt, bus.in_ready);
    end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_post_rst: got ready %b valid %b want 1 0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_cnt_saturate();
    bus_c.out_ready = 1'b1;
    bus_c.in_nan    = 1'b0;
    bus_c.in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_c.in_result = 32'h3F800000 + i;
      tick();
      if (i == 1) begin
        n_checks++; if (cnt_c !== 2'd2) begin n_fail++; $display("[TB] FAIL sat_mid: got %0d want 2", cnt_c); end
      end
    end
    bus_c.in_valid  = 1'b0;
    n_checks++; if (cnt_c !== 2'd3) begin n_fail++; $display("[TB] FAIL sat_end: got %0d want 3", cnt_c); end
    tick();
    bus_c.out_ready = 1'b0;
    n_checks++; if (level_c !== 3'd0 || cnt_c !== 2'd3) begin n_fail++; $display("[TB] FAIL sat_hold: got level %0d cnt %0d want 0/3", level_c, cnt_c); end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    clr_sticky      = 1'b0;
    clr_sticky_c    = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_result   = 32'h0;
    bus.in_nan      = 1'b0;
    bus.out_ready   = 1'b0;
    bus_c.in_valid  = 1'b0;
    bus_c.in_result = 32'h0;
    bus_c.in_nan    = 1'b0;
    bus_c.out_ready = 1'b0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_flags();
    test_sticky_clear();
    test_reset_mid();
    test_cnt_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
